// File: rtl/rtc_mux_bus_master_if.sv
// ---------------------------------------------------------------------------
// rtc_mux_bus_master_if
//
// Command handshake and strobe bundle for rtc_mux_bus_master.
//   start, rw, addr, wdata : command from the PicoBlaze port registers
//   rdata                  : last read data
//   busy, done             : transaction status (done is a one-cycle pulse)
//   AD, CS, WR, RD         : registered pin strobes (all active-low except AD,
//                            which is low during the address phase)
// The multiplexed data bus itself is a plain inout port on the master so the
// tristate resolves directly at the board pin.
//
// Modports:
//   master : the bus master block
//   slave  : the command source / observer
// ---------------------------------------------------------------------------
interface rtc_mux_bus_master_if #(
    parameter int N = 8
);
    logic         start;
    logic         rw;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         busy;
    logic         done;
    logic         AD;
    logic         CS;
    logic         WR;
    logic         RD;

    modport master (
        input  start, rw, addr, wdata,
        output rdata, busy, done, AD, CS, WR, RD
    );

    modport slave (
        output start, rw, addr, wdata,
        input  rdata, busy, done, AD, CS, WR, RD
    );
endinterface

// File: rtl/rtc_mux_bus_master.sv
// ---------------------------------------------------------------------------
// rtc_mux_bus_master
//
// Bus master for multiplexed address/data peripherals (e.g. the board RTC).
// A single read or write command runs a timed address cycle (setup, strobe,
// hold), an idle gap, then a timed data cycle, and finishes with a one-cycle
// done pulse. All pin outputs come straight from flops.
//
// Ports:
//   clk     : system clock
//   reset   : synchronous, active-high; aborts any transaction, no done pulse
//   bus     : rtc_mux_bus_master_if.master (command, status and strobes)
//   salient : N-bit multiplexed address/data bus, tristated when not driven
//
// Parameters: N (bus width), T_SU, T_PW, T_HD (setup / strobe / hold cycles
// of each phase), T_GAP (idle cycles between address and data cycles).
//
// Optional feature macro: ADDR_CACHE_EN
//   When defined, the last address sent is remembered; a command to the same
//   address skips straight to the data cycle.
// ---------------------------------------------------------------------------
module rtc_mux_bus_master #(
    parameter int N     = 8,
    parameter int T_SU  = 2,
    parameter int T_PW  = 4,
    parameter int T_HD  = 2,
    parameter int T_GAP = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    rtc_mux_bus_master_if.master  bus,
    inout  wire  [N-1:0]          salient
);
    localparam int T_A   = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int T_B   = (T_HD > T_GAP) ? T_HD : T_GAP;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_A_SU, S_A_PW, S_A_HD, S_GAP, S_D_SU, S_D_PW, S_D_HD, S_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           rw_reg, rw_next;
    logic [N-1:0]   addr_reg, addr_next;
    logic [N-1:0]   wdata_reg, wdata_next;
    logic [N-1:0]   rdata_reg;
    logic           ad_reg, cs_reg, wr_reg, rd_reg, busy_reg, done_reg;
    logic           ad_next, cs_next, wr_next, rd_next, busy_next, done_next;
    logic           bus_oe_reg, bus_oe_next;
    logic [N-1:0]   bus_out_reg, bus_out_next;
    logic           cache_hit;

    // Counter holds (cycles remaining - 1) in the current timed state.
    function automatic logic [CW-1:0] phase_len(input state_t s);
        case (s)
            S_A_SU, S_D_SU: phase_len = CW'(T_SU - 1);
            S_A_PW, S_D_PW: phase_len = CW'(T_PW - 1);
            S_A_HD, S_D_HD: phase_len = CW'(T_HD - 1);
            S_GAP:          phase_len = CW'(T_GAP - 1);
            default:        phase_len = '0;
        endcase
    endfunction

    wire launch = (state_reg == S_IDLE) && bus.start;

    // Command is captured on launch; the output decode below uses these
    // next values so the first cycle of A_SU already shows the new address.
    assign rw_next    = launch ? bus.rw    : rw_reg;
    assign addr_next  = launch ? bus.addr  : addr_reg;
    assign wdata_next = launch ? bus.wdata : wdata_reg;

`ifdef ADDR_CACHE_EN
    logic [N-1:0] cache_addr_reg;
    logic         cache_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_addr_reg  <= '0;
            cache_valid_reg <= 1'b0;
        end else if (state_reg == S_A_HD && state_next == S_GAP) begin
            cache_addr_reg  <= addr_reg;
            cache_valid_reg <= 1'b1;
        end
    end

    assign cache_hit = cache_valid_reg && (bus.addr == cache_addr_reg);
`else
    assign cache_hit = 1'b0;
`endif

    // Next-state and phase counter.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: if (bus.start) state_next = cache_hit ? S_D_SU : S_A_SU;
            S_DONE: state_next = S_IDLE;
            default: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    case (state_reg)
                        S_A_SU:  state_next = S_A_PW;
                        S_A_PW:  state_next = S_A_HD;
                        S_A_HD:  state_next = S_GAP;
                        S_GAP:   state_next = S_D_SU;
                        S_D_SU:  state_next = S_D_PW;
                        S_D_PW:  state_next = S_D_HD;
                        S_D_HD:  state_next = S_DONE;
                        default: state_next = S_IDLE;
                    endcase
                end
            end
        endcase
        if (state_next != state_reg) cnt_next = phase_len(state_next);
    end

    // Pin values for the state being entered; registered below.
    always_comb begin
        ad_next      = 1'b1;
        cs_next      = 1'b1;
        wr_next      = 1'b1;
        rd_next      = 1'b1;
        bus_oe_next  = 1'b0;
        bus_out_next = addr_next;
        busy_next    = (state_next != S_IDLE);
        done_next    = (state_next == S_DONE);
        case (state_next)
            S_A_SU, S_A_HD: begin
                ad_next     = 1'b0;
                bus_oe_next = 1'b1;
            end
            S_A_PW: begin
                ad_next     = 1'b0;
                cs_next     = 1'b0;
                wr_next     = 1'b0;
                bus_oe_next = 1'b1;
            end
            S_D_SU, S_D_HD: begin
                bus_out_next = wdata_next;
                bus_oe_next  = !rw_next;
            end
            S_D_PW: begin
                bus_out_next = wdata_next;
                bus_oe_next  = !rw_next;
                cs_next      = 1'b0;
                wr_next      = rw_next;
                rd_next      = !rw_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            rw_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            ad_reg      <= 1'b1;
            cs_reg      <= 1'b1;
            wr_reg      <= 1'b1;
            rd_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            bus_oe_reg  <= 1'b0;
            bus_out_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rw_reg      <= rw_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            ad_reg      <= ad_next;
            cs_reg      <= cs_next;
            wr_reg      <= wr_next;
            rd_reg      <= rd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            bus_oe_reg  <= bus_oe_next;
            bus_out_reg <= bus_out_next;
            // Sample the peripheral at the end of the last RD-low cycle.
            if (state_reg == S_D_PW && cnt_reg == '0 && rw_reg)
                rdata_reg <= salient;
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.AD    = ad_reg;
    assign bus.CS    = cs_reg;
    assign bus.WR    = wr_reg;
    assign bus.RD    = rd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bus
            assign salient[gi] = bus_oe_reg ? bus_out_reg[gi] : 1'bz;
        end
    endgenerate
endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// ---------------------------------------------------------------------------
// tb_rtc_mux_bus_master
//
// Two instances: default parameters (sel=0) and N=4/T_PW=1/T_GAP=1 (sel=1).
// Each transaction's expected pin/bus sequence is built as a list of phases
// (length, pin pattern, who owns the bus) and compared cycle by cycle. When
// the master should float the bus, the bench drives a random probe value and
// expects to read it back unchanged; a peripheral model answers while RD=0.
// ---------------------------------------------------------------------------
module tb_rtc_mux_bus_master;
    localparam int N = 8, T_SU = 2, T_PW = 4, T_HD = 2, T_GAP = 4;
    localparam int SN = 4, S_PW = 1, S_GAP = 1;
`ifdef ADDR_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic       sel = 1'b0;
    logic       start_d = 1'b0;
    logic       rw_d = 1'b0;
    logic [7:0] addr_d = 8'h00;
    logic [7:0] wdata_d = 8'h00;
    logic [7:0] periph_val = 8'h00;
    logic [7:0] probe_val = 8'h00;
    logic       probe_en = 1'b0;

    rtc_mux_bus_master_if #(.N(N))  bif ();
    rtc_mux_bus_master_if #(.N(SN)) sif ();
    wire [N-1:0]  bus_big;
    wire [SN-1:0] bus_small;

    assign bif.start = start_d & ~sel;
    assign bif.rw    = rw_d;
    assign bif.addr  = addr_d;
    assign bif.wdata = wdata_d;
    assign sif.start = start_d & sel;
    assign sif.rw    = rw_d;
    assign sif.addr  = addr_d[SN-1:0];
    assign sif.wdata = wdata_d[SN-1:0];

    assign bus_big   = (!bif.RD) ? periph_val :
                       ((probe_en && !sel) ? probe_val : 'z);
    assign bus_small = (!sif.RD) ? periph_val[SN-1:0] :
                       ((probe_en && sel) ? probe_val[SN-1:0] : 'z);

    rtc_mux_bus_master #(.N(N), .T_SU(T_SU), .T_PW(T_PW), .T_HD(T_HD), .T_GAP(T_GAP)) u_dut (
        .clk(clk), .reset(reset), .bus(bif), .salient(bus_big)
    );
    rtc_mux_bus_master #(.N(SN), .T_SU(T_SU), .T_PW(S_PW), .T_HD(T_HD), .T_GAP(S_GAP)) u_small (
        .clk(clk), .reset(reset), .bus(sif), .salient(bus_small)
    );

    // {AD, CS, WR, RD, busy, done}
    wire [5:0] pins_obs  = sel ? {sif.AD, sif.CS, sif.WR, sif.RD, sif.busy, sif.done}
                               : {bif.AD, bif.CS, bif.WR, bif.RD, bif.busy, bif.done};
    wire [7:0] bus_obs   = sel ? {{(8-SN){1'b0}}, bus_small} : bus_big;
    wire [7:0] rdata_obs = sel ? {{(8-SN){1'b0}}, sif.rdata} : bif.rdata;

    // Reference model state per instance.
    bit         cache_valid [2] = '{1'b0, 1'b0};
    logic [7:0] cache_addr  [2] = '{8'h00, 8'h00};
    logic [7:0] model_rdata [2] = '{8'h00, 8'h00};

    // Expected per-cycle sequence. Bus owner: 0 float, 1 addr, 2 wdata, 3 peripheral.
    logic [5:0] exp_pins [$];
    int         exp_kind [$];

    task automatic add_phase(input int n, input logic [5:0] p, input int k);
        repeat (n) begin
            exp_pins.push_back(p);
            exp_kind.push_back(k);
        end
    endtask

    task automatic run_txn(input logic rw, input logic [7:0] a_in, input logic [7:0] wd_in,
                           input logic [7:0] pv_in, input bit hold_start, input bit chained,
                           input int pulse_cycle, input int abort_cycle);
        int tsu, tpw, thd, tgap, idx, lat_exp, done_cyc, kind, len;
        logic [7:0] mask, a, wd, pv, exp_bus, rdata_exp;
        bit hit;
        idx  = sel ? 1 : 0;
        tsu  = T_SU;
        thd  = T_HD;
        tpw  = sel ? S_PW : T_PW;
        tgap = sel ? S_GAP : T_GAP;
        mask = sel ? 8'h0F : 8'hFF;
        a    = a_in & mask;
        wd   = wd_in & mask;
        pv   = pv_in & mask;
        hit  = CACHE_EN && cache_valid[idx] && (cache_addr[idx] == a);

        exp_pins.delete();
        exp_kind.delete();
        if (!hit) begin
            add_phase(tsu,  6'b011110, 1);
            add_phase(tpw,  6'b000110, 1);
            add_phase(thd,  6'b011110, 1);
            add_phase(tgap, 6'b111110, 0);
        end
        add_phase(tsu, 6'b111110, rw ? 0 : 2);
        add_phase(tpw, rw ? 6'b101010 : 6'b100110, rw ? 3 : 2);
        add_phase(thd, 6'b111110, rw ? 0 : 2);
        add_phase(1,   6'b111111, 0);
        lat_exp   = hit ? (1 + tsu + tpw + thd) : (1 + 2 * tsu + 2 * tpw + 2 * thd + tgap);
        rdata_exp = rw ? pv : model_rdata[idx];

        if (!chained) @(negedge clk);
        start_d    = 1'b1;
        rw_d       = rw;
        addr_d     = a_in;
        wdata_d    = wd_in;
        periph_val = pv_in;
        probe_en   = 1'b0;

        done_cyc = -1;
        len = exp_pins.size();
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (!hold_start) start_d = (c == pulse_cycle);
            if (c == pulse_cycle) addr_d = ~a_in;
            kind      = exp_kind[c-1];
            probe_val = 8'($urandom);
            probe_en  = (kind == 0);
            #1;
            case (kind)
                1:       exp_bus = a;
                2:       exp_bus = wd;
                3:       exp_bus = pv;
                default: exp_bus = probe_val & mask;
            endcase
            tests++;
            if (pins_obs !== exp_pins[c-1]) begin
                fails++;
                $display("FAIL pins sel=%0d cycle=%0d: got %b expected %b (AD CS WR RD busy done)",
                         sel, c, pins_obs, exp_pins[c-1]);
            end
            tests++;
            if (bus_obs !== exp_bus) begin
                fails++;
                $display("FAIL bus sel=%0d cycle=%0d: got %h expected %h", sel, c, bus_obs, exp_bus);
            end
            if (pins_obs[0] && done_cyc < 0) done_cyc = c;
            if (c == abort_cycle) begin
                reset = 1'b1;
                @(negedge clk);
                start_d   = 1'b0;
                probe_val = 8'($urandom);
                probe_en  = 1'b1;
                #1;
                tests++;
                if (pins_obs !== 6'b111100) begin
                    fails++;
                    $display("FAIL abort_pins: got %b expected 111100", pins_obs);
                end
                tests++;
                if (bus_obs !== (probe_val & mask)) begin
                    fails++;
                    $display("FAIL abort_bus: got %h expected %h", bus_obs, probe_val & mask);
                end
                tests++;
                if (rdata_obs !== 8'h00) begin
                    fails++;
                    $display("FAIL abort_rdata: got %h expected 00", rdata_obs);
                end
                reset = 1'b0;
                cache_valid[0] = 1'b0;
                cache_valid[1] = 1'b0;
                model_rdata[0] = 8'h00;
                model_rdata[1] = 8'h00;
                $display("[TB] txn sel=%0d rw=%0d addr=%h aborted by reset at cycle %0d", sel, rw, a, c);
                return;
            end
        end

        @(negedge clk);
        if (!hold_start) start_d = 1'b0;
        probe_val = 8'($urandom);
        probe_en  = 1'b1;
        #1;
        tests++;
        if (pins_obs !== 6'b111100) begin
            fails++;
            $display("FAIL idle_after_done sel=%0d: got %b expected 111100", sel, pins_obs);
        end
        tests++;
        if (bus_obs !== (probe_val & mask)) begin
            fails++;
            $display("FAIL idle_bus sel=%0d: got %h expected %h", sel, bus_obs, probe_val & mask);
        end
        tests++;
        if (rdata_obs !== rdata_exp) begin
            fails++;
            $display("FAIL rdata sel=%0d: got %h expected %h", sel, rdata_obs, rdata_exp);
        end
        tests++;
        if (done_cyc != lat_exp) begin
            fails++;
            $display("FAIL latency sel=%0d: done at cycle %0d expected %0d", sel, done_cyc, lat_exp);
        end
        model_rdata[idx] = rdata_exp;
        if (CACHE_EN && !hit) begin
            cache_valid[idx] = 1'b1;
            cache_addr[idx]  = a;
        end
        $display("[TB] txn sel=%0d rw=%0d addr=%h wdata=%h rdata=%h done@%0d hit=%0d",
                 sel, rw, a, wd, rdata_obs, done_cyc, hit);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start_d = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel       = (s == 1);
            probe_val = 8'($urandom);
            probe_en  = 1'b1;
            #1;
            tests++;
            if (pins_obs !== 6'b111100) begin
                fails++;
                $display("FAIL reset_pins sel=%0d: got %b expected 111100", sel, pins_obs);
            end
            tests++;
            if (bus_obs !== (probe_val & (sel ? 8'h0F : 8'hFF))) begin
                fails++;
                $display("FAIL reset_bus sel=%0d: got %h expected %h", sel, bus_obs, probe_val);
            end
            tests++;
            if (rdata_obs !== 8'h00) begin
                fails++;
                $display("FAIL reset_rdata sel=%0d: got %h expected 00", sel, rdata_obs);
            end
        end
        reset    = 1'b0;
        sel      = 1'b0;
        probe_en = 1'b0;
    endtask

    task automatic test_write();
        run_txn(1'b0, 8'h21, 8'h5A, 8'h00, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_read();
        run_txn(1'b1, 8'h24, 8'($urandom), 8'h37, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_ignored_start();
        run_txn(1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0, 5, 0);
    endtask

    task automatic test_abort();
        run_txn(1'b0, cache_addr[0] ^ 8'h55, 8'($urandom), 8'h00, 1'b0, 1'b0, 0, 12);
        run_txn(1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_cache();
        run_txn(1'b0, 8'h21, 8'($urandom), 8'h00, 1'b0, 1'b0, 0, 0);
        run_txn(1'b1, 8'h21, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, 0);
        run_txn(1'b1, 8'h22, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 8'h40, 8'($urandom), 8'h00, 1'b1, 1'b0, 0, 0);
        run_txn(1'b1, 8'h41, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 0, 0);
    endtask

    task automatic test_random();
        logic       r;
        logic [7:0] a;
        for (int i = 0; i < 6; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 8'h08 | 8'($urandom_range(0, 3));
            run_txn(r, a, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, 0);
        end
    endtask

    task automatic test_small_params();
        sel = 1'b1;
        run_txn(1'b0, 8'h0A, 8'h05, 8'h00, 1'b0, 1'b0, 0, 0);
        run_txn(1'b1, 8'h0A, 8'h00, 8'($urandom), 1'b0, 1'b0, 0, 0);
        run_txn(1'b1, 8'h03, 8'h00, 8'($urandom), 1'b0, 1'b0, 0, 0);
        run_txn(1'b0, 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0, 0, 0);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignored_start();
        test_abort();
        test_cache();
        test_back_to_back();
        test_random();
        test_small_params();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
